// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-key debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    KS_RELEASED = 2'd0,
    KS_PRESSED  = 2'd1,
    KS_HELD     = 2'd2
  } key_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, debounce filter, press FSM and registered pulses.
// state       | meaning
// KS_RELEASED | key not pressed, waiting for an accepted press
// KS_PRESSED  | press accepted, counting towards the long-hold pulse
// KS_HELD     | long hold reached, emitting auto-repeat pulses
module key_channel
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_hold,
  output logic key_repeat
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int RW = cnt_w(REPEAT_CYCLES);
  localparam logic INACT = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DB_TC   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_TC  = RW'(REPEAT_CYCLES - 1);

  logic          sync1, sync2, raw_act;
  logic          db_hit, acc_press, acc_release;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  key_state_t    state;

  assign raw_act     = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign db_hit      = (raw_act != key_level) && (db_cnt == DB_TC);
  assign acc_press   = db_hit && raw_act;
  assign acc_release = db_hit && !raw_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= INACT;
      sync2       <= INACT;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      state       <= KS_RELEASED;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_hold    <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      sync1       <= key_in;
      sync2       <= sync1;
      key_press   <= acc_press;
      key_release <= acc_release;
      key_hold    <= 1'b0;
      key_repeat  <= 1'b0;

      if (raw_act == key_level) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        db_cnt    <= '0;
        key_level <= raw_act;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // An accepted release overrides any hold/repeat terminal count this cycle.
      if (acc_release) begin
        state    <= KS_RELEASED;
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else begin
        case (state)
          KS_RELEASED: begin
            if (acc_press) begin
              state    <= KS_PRESSED;
              hold_cnt <= '0;
            end
          end
          KS_PRESSED: begin
            if (hold_cnt == HOLD_TC) begin
              key_hold <= 1'b1;
              state    <= KS_HELD;
              rep_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          KS_HELD: begin
            if (REPEAT_EN != 0) begin
              if (rep_cnt == REP_TC) begin
                key_repeat <= 1'b1;
                rep_cnt    <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
          default: state <= KS_RELEASED;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_debouncer_multi.sv
// NUM_KEYS independent debounced key channels with press/release/hold/repeat pulses.
module key_debouncer_multi #(
  parameter int NUM_KEYS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : gen_ch
    key_channel #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (REPEAT_EN)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .key_in     (key_in[g]),
      .key_level  (key_level[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_hold   (key_hold[g]),
      .key_repeat (key_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer_multi.sv
// Directed bench for key_debouncer_multi: vector table plus timed corner-case sequences.
module tb_key_debouncer_multi;

  localparam int NK = 2;
  localparam int HN = 512;
  localparam int K_LVL = 0, K_PRS = 1, K_REL = 2, K_HLD = 3, K_REP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_in, key_level, key_press, key_release, key_hold, key_repeat;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [NK-1:0] h_lvl [HN];
  logic [NK-1:0] h_prs [HN];
  logic [NK-1:0] h_rel [HN];
  logic [NK-1:0] h_hld [HN];
  logic [NK-1:0] h_rep [HN];

  typedef struct {
    logic [NK-1:0] kin;
    logic [NK-1:0] lvl, prs, rel, hld, rep;
  } vec_t;
  vec_t vt[31];

  always #5 clk = ~clk;

  key_debouncer_multi #(
    .NUM_KEYS(NK), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_hold(key_hold), .key_repeat(key_repeat)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < HN) begin
      h_lvl[cyc] = key_level;
      h_prs[cyc] = key_press;
      h_rel[cyc] = key_release;
      h_hld[cyc] = key_hold;
      h_rep[cyc] = key_repeat;
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NK-1:0] hget(input int kind, input int c);
    logic [NK-1:0] v;
    v = '0;
    if (c >= 0 && c < HN) begin
      case (kind)
        K_LVL:   v = h_lvl[c];
        K_PRS:   v = h_prs[c];
        K_REL:   v = h_rel[c];
        K_HLD:   v = h_hld[c];
        default: v = h_rep[c];
      endcase
    end
    return v;
  endfunction

  function automatic int count(input int kind, input int ch, input int a, input int b);
    int s;
    logic [NK-1:0] v;
    s = 0;
    for (int c = a; c <= b; c++) begin
      v = hget(kind, c);
      s += int'(v[ch]);
    end
    return s;
  endfunction

  task automatic chk_at(input string name, input int kind, input int ch, input int c, input logic exp);
    logic [NK-1:0] v;
    v = hget(kind, c);
    chk(name, 32'(v[ch]), 32'(exp));
  endtask

  initial begin
    int c, p;

    // Table: clean press/release on key 0, then a bounce that must be swallowed.
    for (int i = 0; i < 31; i++) vt[i] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 1; i <= 7; i++) vt[i].kin = 2'b10;
    for (int i = 6; i <= 12; i++) vt[i].lvl = 2'b01;
    vt[6].prs  = 2'b01;
    vt[13].rel = 2'b01;
    for (int i = 15; i <= 17; i++) vt[i].kin = 2'b10;
    for (int i = 20; i <= 22; i++) vt[i].kin = 2'b10;

    reset  = 1'b1;
    key_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outputs", {key_level, key_press, key_release, key_hold, key_repeat}, 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      key_in = vt[i].kin;
      step();
      chk($sformatf("v%0d_level", i),   key_level,   vt[i].lvl);
      chk($sformatf("v%0d_press", i),   key_press,   vt[i].prs);
      chk($sformatf("v%0d_release", i), key_release, vt[i].rel);
      chk($sformatf("v%0d_hold", i),    key_hold,    vt[i].hld);
      chk($sformatf("v%0d_repeat", i),  key_repeat,  vt[i].rep);
    end

    // Hold and repeat: press held 30 cycles after acceptance.
    c = cyc;
    p = c + 6;
    key_in = 2'b10;
    step_to(p + 30);
    key_in = 2'b11;
    step_to(p + 40);
    chk_at("t3_press_at", K_PRS, 0, p, 1'b1);
    chk("t3_press_count", count(K_PRS, 0, c + 1, p + 40), 1);
    chk_at("t3_hold_at", K_HLD, 0, p + 10, 1'b1);
    chk("t3_hold_count", count(K_HLD, 0, c + 1, p + 40), 1);
    for (int k = 0; k < 8; k++) chk_at($sformatf("t3_repeat%0d", k), K_REP, 0, p + 13 + 3 * k, 1'b1);
    chk("t3_repeat_count", count(K_REP, 0, c + 1, p + 40), 8);
    chk_at("t3_level_before_rel", K_LVL, 0, p + 35, 1'b1);
    chk_at("t3_release_at", K_REL, 0, p + 36, 1'b1);
    chk_at("t3_level_after_rel", K_LVL, 0, p + 36, 1'b0);
    chk("t3_release_count", count(K_REL, 0, c + 1, p + 40), 1);
    chk("t3_key1_quiet", count(K_PRS, 1, c + 1, p + 40), 0);

    // Release accepted on the same edge as the third repeat terminal count.
    c = cyc;
    p = c + 6;
    key_in = 2'b10;
    step_to(p + 13);
    key_in = 2'b11;
    step_to(p + 30);
    chk_at("t4_release_at", K_REL, 0, p + 19, 1'b1);
    chk_at("t4_no_repeat_on_release", K_REP, 0, p + 19, 1'b0);
    chk_at("t4_level_low", K_LVL, 0, p + 19, 1'b0);
    chk("t4_repeat_count", count(K_REP, 0, c + 1, p + 30), 2);
    chk("t4_hold_count", count(K_HLD, 0, c + 1, p + 30), 1);
    chk("t4_release_count", count(K_REL, 0, c + 1, p + 30), 1);

    // Two channels 2 cycles apart, key 1 glitch, reset while key 0 is HELD, held through reset.
    c = cyc;
    key_in = 2'b10;
    step_to(c + 2);
    key_in = 2'b00;
    step_to(c + 9);
    key_in = 2'b10;
    step_to(c + 11);
    key_in = 2'b00;
    step_to(c + 18);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t5_reset_out%0d", i),
          {key_level, key_press, key_release, key_hold, key_repeat}, 32'd0);
    end
    reset = 1'b0;
    step_to(c + 35);
    chk_at("t5_press0_at", K_PRS, 0, c + 6, 1'b1);
    chk_at("t5_press1_at", K_PRS, 1, c + 8, 1'b1);
    chk("t5_press0_count", count(K_PRS, 0, c + 1, c + 18), 1);
    chk("t5_press1_count", count(K_PRS, 1, c + 1, c + 18), 1);
    chk_at("t5_level1_after_glitch", K_LVL, 1, c + 17, 1'b1);
    chk_at("t5_level0_kept", K_LVL, 0, c + 18, 1'b1);
    chk_at("t5_hold0_at", K_HLD, 0, c + 16, 1'b1);
    chk("t5_no_release0", count(K_REL, 0, c + 1, c + 35), 0);
    chk("t5_no_release1", count(K_REL, 1, c + 1, c + 35), 0);
    chk_at("t6_level1_before", K_LVL, 1, c + 28, 1'b0);
    chk_at("t6_press1_at", K_PRS, 1, c + 29, 1'b1);
    chk("t6_press1_count", count(K_PRS, 1, c + 19, c + 35), 1);
    chk_at("t6_press0_at", K_PRS, 0, c + 29, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
